// File: rtl/custom_hls_ctrl_pkg.sv
// Shared definitions for the HLS kernel control master: register map,
// response code, AXI-lite attribute constants and the sequencer state encoding.
package custom_hls_ctrl_pkg;

  localparam logic [31:0] REG_CTRL = 32'h00;
  localparam logic [31:0] REG_GIE  = 32'h04;
  localparam logic [31:0] REG_IER  = 32'h08;
  localparam logic [31:0] REG_ISR  = 32'h0C;

  localparam logic [31:0] AP_START  = 32'h1;
  localparam logic [31:0] BIT_SET   = 32'h1;
  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [2:0]  AXI_PROT  = 3'b000;
  localparam logic [3:0]  AXI_STRB  = 4'hF;

  typedef enum logic [3:0] {
    IDLE,
    WR_ARG,
    WR_GIE,
    WR_IER,
    WR_START,
    WAIT,
    POLL_AR,
    POLL_R,
    WR_ISR,
    DONE
  } state_t;

  function automatic logic resp_bad(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/custom_hls_ctrl_axil_txn.sv
// Single-transaction AXI-lite engine: accepts one read or write request when
// idle and pulses ack together with the response on the final handshake.
module custom_hls_ctrl_axil_txn
  import custom_hls_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        idle,
  output logic        ack,
  output logic [1:0]  resp,
  output logic [31:0] rsp_data,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic [2:0]  awprot,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic        bvalid,
  output logic        bready,
  input  logic [1:0]  bresp,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [2:0]  arprot,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp
);

  logic        busy;
  logic        accept;
  logic        hs_aw, hs_w, hs_b, hs_ar, hs_r;
  logic [31:0] addr_q;
  logic [31:0] data_q;

  assign accept = req && !busy;
  assign hs_aw  = awvalid && awready;
  assign hs_w   = wvalid && wready;
  assign hs_b   = bvalid && bready;
  assign hs_ar  = arvalid && arready;
  assign hs_r   = rvalid && rready;

  // AW and W retire independently; B is only accepted once one of them has gone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      arvalid <= 1'b0;
      rready  <= 1'b0;
    end else if (accept) begin
      busy    <= 1'b1;
      awvalid <= we;
      wvalid  <= we;
      arvalid <= !we;
    end else begin
      if (hs_aw) awvalid <= 1'b0;
      if (hs_w)  wvalid  <= 1'b0;
      if (hs_aw || hs_w) bready <= 1'b1;
      if (hs_b) begin
        bready <= 1'b0;
        busy   <= 1'b0;
      end
      if (hs_ar) begin
        arvalid <= 1'b0;
        rready  <= 1'b1;
      end
      if (hs_r) begin
        rready <= 1'b0;
        busy   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= req_addr;
      data_q <= req_data;
    end
  end

  assign idle     = !busy;
  assign ack      = hs_b || hs_r;
  assign resp     = rready ? rresp : bresp;
  assign rsp_data = rdata;

  assign awaddr = addr_q;
  assign araddr = addr_q;
  assign wdata  = data_q;
  assign wstrb  = AXI_STRB;
  assign awprot = AXI_PROT;
  assign arprot = AXI_PROT;

endmodule

// File: rtl/custom_hls_ctrl_master.sv
// Launches an HLS kernel over its AXI-lite control slave: writes arguments, sets
// ap_start, then waits for ap_done. Define HLS_CTRL_IRQ_EN to wait on irq_i instead of polling.
`ifndef DEFINE_AXILITE_MASTER_PORTS
`define DEFINE_AXILITE_MASTER_PORTS(p) \
  output logic        ctrl_awvalid, \
  input  logic        ctrl_awready, \
  output logic [31:0] ctrl_awaddr, \
  output logic [2:0]  ctrl_awprot, \
  output logic        ctrl_wvalid, \
  input  logic        ctrl_wready, \
  output logic [31:0] ctrl_wdata, \
  output logic [3:0]  ctrl_wstrb, \
  input  logic        ctrl_bvalid, \
  output logic        ctrl_bready, \
  input  logic [1:0]  ctrl_bresp, \
  output logic        ctrl_arvalid, \
  input  logic        ctrl_arready, \
  output logic [31:0] ctrl_araddr, \
  output logic [2:0]  ctrl_arprot, \
  input  logic        ctrl_rvalid, \
  output logic        ctrl_rready, \
  input  logic [31:0] ctrl_rdata, \
  input  logic [1:0]  ctrl_rresp
`endif

module custom_hls_ctrl_master #(
  parameter logic [31:0] CTRL_BASE  = 32'h0000_0000,
  parameter int          NUM_ARGS   = 4,
  parameter logic [31:0] ARG_OFFSET = 32'h10,
  parameter int          POLL_GAP   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [NUM_ARGS*32-1:0] args_i,
  input  logic                  irq_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  `DEFINE_AXILITE_MASTER_PORTS(ctrl)
);

  import custom_hls_ctrl_pkg::*;

  localparam logic [3:0] LAST_ARG = 4'(NUM_ARGS - 1);

  state_t                  state, state_nxt;
  logic [3:0]              arg_idx;
  logic [NUM_ARGS*32-1:0]  args_q;
  logic                    error_q;

  logic        txn_req, txn_we, txn_idle, txn_ack, txn_bad;
  logic [31:0] txn_addr, txn_data, txn_rdata;
  logic [1:0]  txn_resp;
  logic        unused_sig;

  assign txn_bad = resp_bad(txn_resp);

`ifndef HLS_CTRL_IRQ_EN
  localparam logic [7:0] POLL_LAST = 8'(POLL_GAP - 1);
  logic [7:0] poll_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      poll_cnt <= 8'd0;
    else if (state == WAIT)
      poll_cnt <= (poll_cnt == POLL_LAST) ? 8'd0 : poll_cnt + 8'd1;
    else
      poll_cnt <= 8'd0;
  end
`endif

  always_comb begin
    state_nxt = state;
    txn_req   = 1'b0;
    txn_we    = 1'b1;
    txn_addr  = CTRL_BASE + REG_CTRL;
    txn_data  = AP_START;
    case (state)
      IDLE: if (start_i) state_nxt = WR_ARG;
      WR_ARG: begin
        txn_req  = 1'b1;
        txn_addr = CTRL_BASE + ARG_OFFSET + {26'd0, arg_idx, 2'b00};
        txn_data = args_q[arg_idx*32 +: 32];
        if (txn_ack) begin
          if (txn_bad)
            state_nxt = DONE;
          else if (arg_idx == LAST_ARG)
`ifdef HLS_CTRL_IRQ_EN
            state_nxt = WR_GIE;
`else
            state_nxt = WR_START;
`endif
        end
      end
      WR_GIE: begin
        txn_req  = 1'b1;
        txn_addr = CTRL_BASE + REG_GIE;
        txn_data = BIT_SET;
        if (txn_ack) state_nxt = txn_bad ? DONE : WR_IER;
      end
      WR_IER: begin
        txn_req  = 1'b1;
        txn_addr = CTRL_BASE + REG_IER;
        txn_data = BIT_SET;
        if (txn_ack) state_nxt = txn_bad ? DONE : WR_START;
      end
      WR_START: begin
        txn_req = 1'b1;
        if (txn_ack) state_nxt = txn_bad ? DONE : WAIT;
      end
      WAIT: begin
`ifdef HLS_CTRL_IRQ_EN
        if (irq_i) state_nxt = WR_ISR;
`else
        if (poll_cnt == POLL_LAST) state_nxt = POLL_AR;
`endif
      end
      POLL_AR: begin
        txn_req = 1'b1;
        txn_we  = 1'b0;
        if (txn_idle) state_nxt = POLL_R;
      end
      // ap_done lives in bit 1 of the control register
      POLL_R: if (txn_ack) state_nxt = (txn_bad || txn_rdata[1]) ? DONE : WAIT;
      WR_ISR: begin
        txn_req  = 1'b1;
        txn_addr = CTRL_BASE + REG_ISR;
        txn_data = BIT_SET;
        if (txn_ack) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      arg_idx <= 4'd0;
      error_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start_i) begin
        arg_idx <= 4'd0;
        error_q <= 1'b0;
      end else if (state == WR_ARG && txn_ack && !txn_bad) begin
        arg_idx <= arg_idx + 4'd1;
      end
      if (txn_ack && txn_bad) error_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (state == IDLE && start_i) args_q <= args_i;
  end

  assign busy_o  = (state != IDLE) && (state != DONE);
  assign done_o  = (state == DONE);
  assign error_o = error_q;

`ifdef HLS_CTRL_IRQ_EN
  assign unused_sig = ^{txn_rdata[31:2], txn_rdata[0]};
`else
  assign unused_sig = ^{txn_rdata[31:2], txn_rdata[0], irq_i};
`endif

  custom_hls_ctrl_axil_txn u_txn (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .req      (txn_req),
    .we       (txn_we),
    .req_addr (txn_addr),
    .req_data (txn_data),
    .idle     (txn_idle),
    .ack      (txn_ack),
    .resp     (txn_resp),
    .rsp_data (txn_rdata),
    .awvalid  (ctrl_awvalid),
    .awready  (ctrl_awready),
    .awaddr   (ctrl_awaddr),
    .awprot   (ctrl_awprot),
    .wvalid   (ctrl_wvalid),
    .wready   (ctrl_wready),
    .wdata    (ctrl_wdata),
    .wstrb    (ctrl_wstrb),
    .bvalid   (ctrl_bvalid),
    .bready   (ctrl_bready),
    .bresp    (ctrl_bresp),
    .arvalid  (ctrl_arvalid),
    .arready  (ctrl_arready),
    .araddr   (ctrl_araddr),
    .arprot   (ctrl_arprot),
    .rvalid   (ctrl_rvalid),
    .rready   (ctrl_rready),
    .rdata    (ctrl_rdata),
    .rresp    (ctrl_rresp)
  );

endmodule

// File: doc/custom_hls_ctrl_master.md
CUSTOM_HLS_CTRL_MASTER -- requirements
Module: custom_hls_ctrl_master

Interface
REQ-001 SHALL have parameter CTRL_BASE, default 32'h0000_0000, base address of the kernel's AXI-lite control slave.
REQ-002 SHALL have parameter NUM_ARGS, default 4, range 1..8, number of 32-bit kernel argument registers.
REQ-003 SHALL have parameter ARG_OFFSET, default 32'h10, offset of argument 0; argument i is at CTRL_BASE+ARG_OFFSET+4*i.
REQ-004 SHALL have parameter POLL_GAP, default 8, range 1..255, idle cycles between status polls.
REQ-005 clk_i  input  1  single clock; all logic on its rising edge.
REQ-006 rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 start_i  input  1  launch request; sampled only in IDLE.
REQ-008 args_i  input  NUM_ARGS*32  argument values, captured on accepted start.
REQ-009 irq_i  input  1  kernel interrupt line; used only with the IRQ feature.
REQ-010 busy_o  output  1  high from accepted start until done.
REQ-011 done_o  output  1  one-cycle pulse at run completion.
REQ-012 error_o  output  1  sticky error; cleared on next accepted start.
REQ-013 AXI-lite master port group "ctrl" (AW/W/B/AR/R, 32-bit addr and data) SHALL be declared with DEFINE_AXILITE_MASTER_PORTS(ctrl).

Function
REQ-014 FSM states: IDLE, WR_ARG, WR_GIE, WR_IER, WR_START, WAIT, POLL_AR, POLL_R, WR_ISR, DONE.
REQ-015 IDLE + start_i: capture args_i, clear error_o, set busy_o, set arg index 0, go to WR_ARG next cycle.
REQ-016 Each write: AWVALID and WVALID asserted in the same cycle; each drops independently on its own handshake; BREADY=1 from the first of those handshakes until the B handshake; the next transaction starts no earlier than the cycle after B.
REQ-017 WSTRB=4'hF, AWPROT/ARPROT=3'b000 on all transactions.
REQ-018 WR_ARG writes args[i] to argument address i and increments i; after index NUM_ARGS-1 it goes to WR_GIE (IRQ build) or WR_START.
REQ-019 WR_START writes 32'h1 (ap_start) to CTRL_BASE+0x00, then goes to WAIT.
REQ-020 Polling build: WAIT counts POLL_GAP cycles, then POLL_AR reads CTRL_BASE+0x00; RREADY=1 in POLL_R; if RDATA[1] (ap_done)=1 go to DONE, else return to WAIT.
REQ-021 BRESP or RRESP != 2'b00 SHALL set error_o and go straight to DONE, abandoning the sequence.
REQ-022 DONE: assert done_o for exactly one cycle, drop busy_o the same cycle, return to IDLE; a start_i held high relaunches no earlier than the following cycle.
REQ-023 start_i while busy_o=1 SHALL be ignored.
REQ-024 At most one outstanding transaction at any time; VALID never deasserted before its handshake.

Reset
REQ-025 rst_ni low SHALL asynchronously force IDLE, arg index 0, poll counter 0, and all outputs (VALIDs, READYs, busy_o, done_o, error_o) to 0.
REQ-026 Reset mid-transaction SHALL abandon it; no pending handshake state survives deassertion.

Configuration
REQ-027 Macro HLS_CTRL_IRQ_EN defined: after arguments write 32'h1 to 0x04 (GIE) and 32'h1 to 0x08 (IER); WAIT waits for irq_i=1 instead of polling, then WR_ISR writes 32'h1 to 0x0C (clear ISR), then DONE.
REQ-028 Macro undefined: WR_GIE, WR_IER, WR_ISR unreachable, irq_i ignored, polling per REQ-020.

Structure
REQ-029 Register offsets (0x00, 0x04, 0x08, 0x0C), the state enum, and the OKAY response constant SHALL live in package custom_hls_ctrl_pkg.
REQ-030 One sub-module, custom_hls_ctrl_axil_txn (single AXI-lite read/write transaction engine with req/ack/resp), SHALL be used by the FSM.

Verification
REQ-031 NUM_ARGS=2, args {0x100,0x200}, responder OKAY -> writes 0x10=0x100, 0x14=0x200, 0x00=0x1 in that order.
REQ-032 Polling, kernel reports ap_done on the 3rd read -> exactly 3 reads spaced >=POLL_GAP cycles; done_o one pulse; busy_o low the same cycle.
REQ-033 BRESP=2'b10 on 1st argument write -> error_o=1, done_o pulse, no further AW issued.
REQ-034 AWREADY 4 cycles before WREADY -> AWVALID drops after its handshake, WVALID held until its own; single B accepted.
REQ-035 HLS_CTRL_IRQ_EN, irq_i raised 50 cycles after start -> writes 0x04=1, 0x08=1, 0x00=1, no reads, then 0x0C=1, done_o.
REQ-036 rst_ni low while AWVALID=1 -> all outputs 0 immediately; next start_i runs a full clean sequence.
